// File: rtl/simd_alu_pkg.sv
// Shared types and constants for the SIMD ALU: opcodes, FSM states, lane word, memory geometry.
package simd_alu_pkg;

  localparam int LANES_DEF = 4;
  localparam int WORD_W    = 32;
  localparam int MEM_DEPTH = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DIV_ZERO_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } alu_state_t;

  // Code 4'hF is deliberately left undefined and is reported through err.
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_MUL    = 4'd3,
    OP_DIV    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_XNOR   = 4'd8,
    OP_MIN    = 4'd9,
    OP_MAX    = 4'd10,
    OP_LOAD   = 4'd11,
    OP_STORE  = 4'd12,
    OP_MATADD = 4'd13,
    OP_MATMUL = 4'd14
  } opcodes_t;

endpackage

// File: rtl/simd_alu_if.sv
// Instruction-in / result-out bundle of the SIMD ALU; slave is the ALU, master drives it.
interface simd_alu_if #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int REG_IDX_W = 5
);
  import simd_alu_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  opcodes_t                opcode;
  logic [10:0]             immd;
  logic [REG_IDX_W-1:0]    rd_idx;
  logic [LANES-1:0]        lane_mask;
  logic [LANES*DATA_W-1:0] src0;
  logic [LANES*DATA_W-1:0] src1;
  logic [LANES*DATA_W-1:0] mem_read_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    reg_write_en;
  logic [REG_IDX_W-1:0]    reg_write_idx;
  logic [LANES-1:0]        reg_write_mask;
  logic [LANES*DATA_W-1:0] reg_write_data;
  logic [LANES-1:0]        mem_write_en;
  logic [LANES*ADDR_W-1:0] mem_write_addr;
  logic [LANES*DATA_W-1:0] mem_write_data;
  logic                    err;
  logic                    busy;

  modport slave (
    input  in_valid, opcode, immd, rd_idx, lane_mask, src0, src1, mem_read_data, out_ready,
    output in_ready, out_valid, reg_write_en, reg_write_idx, reg_write_mask, reg_write_data,
           mem_write_en, mem_write_addr, mem_write_data, err, busy
  );

  modport master (
    output in_valid, opcode, immd, rd_idx, lane_mask, src0, src1, mem_read_data, out_ready,
    input  in_ready, out_valid, reg_write_en, reg_write_idx, reg_write_mask, reg_write_data,
           mem_write_en, mem_write_addr, mem_write_data, err, busy
  );

endinterface

// File: rtl/simd_alu_lane_divider.sv
// Single-lane restoring unsigned divider: one quotient bit per cycle, DATA_W cycles after start_i.
module alu_lane_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              last_o,
  output logic [DATA_W-1:0] quotient_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q;
  logic              dvs_zero_q;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    if (start_i) begin
      cnt_d = CNT_W'(DATA_W);
      quo_d = dividend_i;
      rem_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      // Sign of the trial subtraction decides restore vs. keep.
      if (!diff[DATA_W]) begin
        rem_d = diff[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    if (start_i) begin
      dvs_q      <= divisor_i;
      dvs_zero_q <= (divisor_i == '0);
    end
  end

  assign last_o     = (cnt_q == CNT_W'(1));
  assign quotient_o = dvs_zero_q ? '1 : quo_d;

endmodule

// File: rtl/simd_alu.sv
// Multi-lane ALU: one-cycle lane ops, iterative DIV, valid/ready on both sides, IDLE/DIV/DONE FSM.
module simd_alu
  import simd_alu_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int DATA_W    = WORD_W,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int REG_IDX_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  simd_alu_if.slave bus
);

  function automatic logic writes_reg(opcodes_t op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
                      OP_XNOR, OP_MIN, OP_MAX, OP_LOAD};
  endfunction

  function automatic logic is_err(opcodes_t op);
    return !(writes_reg(op) || op == OP_NOP || op == OP_STORE);
  endfunction

  function automatic logic [DATA_W-1:0] lane_op(opcodes_t op, logic [DATA_W-1:0] a,
                                                logic [DATA_W-1:0] b, logic [DATA_W-1:0] m);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_MIN:  return (sa < sb) ? a : b;
      OP_MAX:  return (sa > sb) ? a : b;
      OP_LOAD: return m;
      default: return '0;
    endcase
  endfunction

  alu_state_t              state_q, state_d;
  logic [LANES*DATA_W-1:0] res_q, res_d;
  logic [LANES*DATA_W-1:0] mdata_q, mdata_d;
  logic [LANES*ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [LANES-1:0]        men_q, men_d;
  logic [REG_IDX_W-1:0]    idx_q, idx_d;
  logic                    wen_q, wen_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    div_start;
  logic                    div_last;
  logic [LANES-1:0]        div_last_v;
  logic [DATA_W-1:0]       quo [LANES];
  logic [LANES*DATA_W-1:0] simple_res;
  logic [LANES*DATA_W-1:0] div_res;
  logic [LANES*ADDR_W-1:0] lane_addr;

  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign div_start    = accept && bus.opcode == OP_DIV;
  assign div_last     = &div_last_v;

  for (genvar g = 0; g < LANES; g++) begin : g_div
    alu_lane_divider #(.DATA_W(DATA_W)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (bus.src0[g*DATA_W +: DATA_W]),
      .divisor_i  (bus.src1[g*DATA_W +: DATA_W]),
      .last_o     (div_last_v[g]),
      .quotient_o (quo[g])
    );
  end

  always_comb begin
    simple_res = '0;
    div_res    = '0;
    lane_addr  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_mask[i] && writes_reg(bus.opcode))
        simple_res[i*DATA_W +: DATA_W] = lane_op(bus.opcode, bus.src0[i*DATA_W +: DATA_W],
                                                 bus.src1[i*DATA_W +: DATA_W],
                                                 bus.mem_read_data[i*DATA_W +: DATA_W]);
      if (mask_q[i]) div_res[i*DATA_W +: DATA_W] = quo[i];
      // Power-of-two depth: truncation to ADDR_W bits is the wrap.
      lane_addr[i*ADDR_W +: ADDR_W] = bus.immd[ADDR_W-1:0] + ADDR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    mdata_d = mdata_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    men_d   = men_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) state_d = (bus.opcode == OP_DIV) ? DIV : DONE;
      DIV: if (div_last) begin
        state_d = DONE;
        res_d   = div_res;
      end
      DONE: if (bus.out_ready) begin
        if (accept) state_d = (bus.opcode == OP_DIV) ? DIV : DONE;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      res_d   = simple_res;
      mdata_d = bus.src0;
      addr_d  = lane_addr;
      mask_d  = writes_reg(bus.opcode) ? bus.lane_mask : '0;
      men_d   = (bus.opcode == OP_STORE) ? bus.lane_mask : '0;
      idx_d   = bus.rd_idx;
      wen_d   = writes_reg(bus.opcode);
      err_d   = is_err(bus.opcode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      mdata_q <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      men_q   <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mdata_q <= mdata_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      men_q   <= men_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid      = (state_q == DONE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.reg_write_en   = bus.out_valid && wen_q;
  assign bus.reg_write_idx  = idx_q;
  assign bus.reg_write_mask = mask_q;
  assign bus.reg_write_data = res_q;
  assign bus.mem_write_en   = bus.out_valid ? men_q : '0;
  assign bus.mem_write_addr = addr_q;
  assign bus.mem_write_data = mdata_q;
  assign bus.err            = bus.out_valid && err_q;

endmodule
